// File: rtl/sr_flag_pkg.sv
// Shared command encoding and SR-to-toggle conversion for the flag scheduler.
package sr_flag_pkg;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_RST  = 2'b01;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_BAD  = 2'b11;

    // Toggle needed to move a T-flop holding qbit to the SR-requested value.
    function automatic logic sr_to_t(input logic [1:0] cmd, input logic qbit);
        logic v_t;
        v_t = 1'b0;
        case (cmd)
            CMD_SET: v_t = ~qbit;
            CMD_RST: v_t = qbit;
            default: v_t = 1'b0;
        endcase
        return v_t;
    endfunction

endpackage

// File: rtl/t_flag_bank.sv
// Bank of T flip-flops with per-bit toggle enable; q and qbar always complementary.
module t_flag_bank #(
    parameter int N_FLAGS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_FLAGS-1:0] i_t,
    output logic [N_FLAGS-1:0] o_q,
    output logic [N_FLAGS-1:0] o_qbar
);

    logic [N_FLAGS-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_q ^ i_t;
        end
    end

    assign o_q    = r_q;
    assign o_qbar = ~r_q;

endmodule

// File: rtl/sr_flag_scheduler.sv
// Round-robin scheduler applying SR commands from several requesters to a shared T-flop flag bank.
module sr_flag_scheduler
    import sr_flag_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int N_FLAGS = 8,
    parameter int AW      = 3,
    parameter int IDW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [2*N_REQ-1:0]  cmd,
    input  logic [AW*N_REQ-1:0] addr,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_FLAGS-1:0]  q,
    output logic [N_FLAGS-1:0]  qbar,
    output logic                done,
    output logic [IDW-1:0]      done_id,
    output logic                err,
    input  logic                err_clr
);

    logic [IDW-1:0]     r_ptr;
    logic               r_p_valid;
    logic [IDW-1:0]     r_p_id;
    logic [1:0]         r_p_cmd;
    logic [AW-1:0]      r_p_addr;
    logic               r_done;
    logic [IDW-1:0]     r_done_id;
    logic               r_err;

    logic               w_any;
    logic [IDW-1:0]     w_gnt_idx;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [1:0]         w_sel_cmd;
    logic [AW-1:0]      w_sel_addr;
    logic [N_FLAGS-1:0] w_t;
    logic [N_FLAGS-1:0] w_q;
    logic               w_hit;
    logic               w_err_evt;

    // Arbiter: first requester at or after the pointer, wrapping.
    always_comb begin
        int v_idx;
        v_idx     = 0;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_any && req[v_idx]) begin
                w_any     = 1'b1;
                w_gnt_idx = IDW'(v_idx);
            end
        end
        if (rst) begin
            w_any = 1'b0;
        end
    end

    assign gnt        = w_any ? (N_REQ'(1) << w_gnt_idx) : '0;
    assign w_sel_cmd  = cmd[2*int'(w_gnt_idx) +: 2];
    assign w_sel_addr = addr[AW*int'(w_gnt_idx) +: AW];
    assign w_ptr_nxt  = (int'(w_gnt_idx) == N_REQ-1) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_p_valid <= 1'b0;
            r_p_id    <= '0;
            r_p_cmd   <= CMD_HOLD;
            r_p_addr  <= '0;
        end else begin
            r_p_valid <= w_any;
            if (w_any) begin
                r_ptr    <= w_ptr_nxt;
                r_p_id   <= w_gnt_idx;
                r_p_cmd  <= w_sel_cmd;
                r_p_addr <= w_sel_addr;
            end
        end
    end

    // Out-of-range addresses match no bit, so they toggle nothing and flag an error.
    always_comb begin
        w_t   = '0;
        w_hit = 1'b0;
        for (int b = 0; b < N_FLAGS; b++) begin
            if (r_p_addr == AW'(b)) begin
                w_hit = 1'b1;
                if (r_p_valid && (r_p_cmd != CMD_BAD)) begin
                    w_t[b] = sr_to_t(r_p_cmd, w_q[b]);
                end
            end
        end
    end

    assign w_err_evt = r_p_valid && ((r_p_cmd == CMD_BAD) || !w_hit);

    t_flag_bank #(
        .N_FLAGS (N_FLAGS)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .i_t    (w_t),
        .o_q    (w_q),
        .o_qbar (qbar)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_err     <= 1'b0;
        end else begin
            r_done <= r_p_valid;
            if (r_p_valid) begin
                r_done_id <= r_p_id;
            end
            if (w_err_evt) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign q       = w_q;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign err     = r_err;

endmodule
